mem_fifo_drainer: RTL and testbench

MEM_FIFO_DRAINER -- requirements
Module: mem_fifo_drainer

---
 rtl/mem_fifo_drainer.sv | 170 +++++++++++++++++
 tb/tb_mem_fifo_drainer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_drainer.sv
// ----------------------------------------------------------------------------
// mem_fifo_drainer
//
// Drains an external MEM_FIFO while the data-valid gate is high and frames
// the payload as a burst: header word, payload words in FIFO order, trailer
// word. A 2-entry skid buffer absorbs the one-cycle FIFO read latency, so the
// block streams one word per cycle while downstream is ready and never drops
// or duplicates a word when downstream stalls.
//
// Header  : {HDR_TAG, 32'h0, burst_id[15:0]}        with out_sof_o = 1
// Trailer : {TRL_TAG, 16'h0, word_count[31:0]}      with out_eof_o = 1
//
// Ports
//   clk_i         in   single clock, rising edge
//   reset_i       in   synchronous, active-high reset
//   data_valid_i  in   burst gate; a rising edge in IDLE starts a burst
//   fifo_empty_i  in   MEM_FIFO empty flag
//   fifo_rdata_i  in   MEM_FIFO read data, valid one cycle after fifo_re_o
//   fifo_re_o     out  MEM_FIFO read strobe, one word per high cycle
//   out_data_o    out  output word (header, payload or trailer)
//   out_valid_o   out  out_data_o holds a valid word
//   out_ready_i   in   downstream ready; transfer on valid & ready
//   out_sof_o     out  high while the header word is presented
//   out_eof_o     out  high while the trailer word is presented
//   busy_o        out  high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module mem_fifo_drainer #(
    parameter int unsigned DATA_W  = 64,
    parameter logic [15:0] HDR_TAG = 16'hA5A5,
    parameter logic [15:0] TRL_TAG = 16'h5A5A
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              data_valid_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_rdata_i,
    output logic              fifo_re_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sof_o,
    output logic              out_eof_o,
    output logic              busy_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_TRAILER = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_dv_q;
    logic              r_inflight;
    logic [1:0]        r_occ;
    logic              r_head;
    logic              r_tail;
    logic [DATA_W-1:0] r_buf [2];
    logic [31:0]       r_word_count;
    logic [15:0]       r_burst_id;

    logic              w_rise;
    logic              w_xfer;
    logic              w_pop;
    logic              w_room;
    logic [1:0]        w_occ_nxt;
    logic [DATA_W-1:0] w_hdr_word;
    logic [DATA_W-1:0] w_trl_word;

    assign w_rise     = data_valid_i & ~r_dv_q;
    assign w_xfer     = out_valid_o & out_ready_i;
    assign w_pop      = w_xfer & ((r_state == S_STREAM) | (r_state == S_DRAIN));
    assign w_occ_nxt  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

    // A read may issue only if the word it returns next cycle is guaranteed a
    // free slot: occ + inflight - pop < 2, rearranged to avoid underflow.
    assign w_room     = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    assign fifo_re_o  = (r_state == S_STREAM) & data_valid_i & ~fifo_empty_i & w_room;
    assign busy_o     = (r_state != S_IDLE);

    assign w_hdr_word = {HDR_TAG, 32'h0, r_burst_id};
    assign w_trl_word = {TRL_TAG, 16'h0, r_word_count};

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_sof_o   = 1'b0;
        out_eof_o   = 1'b0;
        case (r_state)
            S_HEADER: begin
                out_valid_o = 1'b1;
                out_data_o  = w_hdr_word;
                out_sof_o   = 1'b1;
            end
            S_STREAM, S_DRAIN: begin
                out_valid_o = (r_occ != 2'd0);
                out_data_o  = r_buf[r_head];
            end
            S_TRAILER: begin
                out_valid_o = 1'b1;
                out_data_o  = w_trl_word;
                out_eof_o   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_rise)        w_state_nxt = S_HEADER;
            S_HEADER:  if (w_xfer)        w_state_nxt = S_STREAM;
            // A falling gate blocks the read in this same cycle (fifo_re_o
            // includes data_valid_i) and moves to DRAIN.
            S_STREAM:  if (!data_valid_i) w_state_nxt = S_DRAIN;
            // Leave once nothing is in flight and the buffer is empty after
            // any pop happening this cycle.
            S_DRAIN:   if (!r_inflight && (w_occ_nxt == 2'd0)) w_state_nxt = S_TRAILER;
            S_TRAILER: if (w_xfer)        w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_dv_q       <= 1'b0;
            r_inflight   <= 1'b0;
            r_occ        <= 2'd0;
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
            r_word_count <= 32'd0;
            r_burst_id   <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_dv_q     <= data_valid_i;
            r_inflight <= fifo_re_o;
            r_occ      <= w_occ_nxt;
            if (r_inflight) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if ((r_state == S_HEADER) && w_xfer) begin
                r_word_count <= 32'd0;
            end else if (w_pop && (r_word_count != 32'hFFFF_FFFF)) begin
                r_word_count <= r_word_count + 32'd1;
            end
            if ((r_state == S_TRAILER) && w_xfer) begin
                r_burst_id <= r_burst_id + 16'd1;
            end
        end
    end

    // NOTE: the skid buffer storage is not reset; occupancy and pointers are,
    // so stale contents are never presented as valid.
    always_ff @(posedge clk_i) begin
        if (r_inflight) begin
            r_buf[r_tail] <= fifo_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_fifo_drainer.sv
// ----------------------------------------------------------------------------
// tb_mem_fifo_drainer
//
// Directed bench for mem_fifo_drainer. A simple FIFO model feeds the block;
// the stimulus process pushes the expected header/payload/trailer words into
// a scoreboard queue and a negedge monitor pops and compares every transfer,
// also watching for reads of an empty FIFO and unstable data while stalled.
// ----------------------------------------------------------------------------
module tb_mem_fifo_drainer;

    localparam logic [15:0] HDR_TAG = 16'hA5A5;
    localparam logic [15:0] TRL_TAG = 16'h5A5A;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        data_valid_i;
    logic        fifo_empty_i;
    logic [63:0] fifo_rdata_i = '0;
    logic        fifo_re_o;
    logic [63:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_sof_o;
    logic        out_eof_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    mem_fifo_drainer #(
        .DATA_W  (64),
        .HDR_TAG (HDR_TAG),
        .TRL_TAG (TRL_TAG)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .data_valid_i (data_valid_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_re_o    (fifo_re_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_sof_o    (out_sof_o),
        .out_eof_o    (out_eof_o),
        .busy_o       (busy_o)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // FIFO model: synchronous read, data valid the cycle after the strobe.
    logic [63:0] fifo_mem [64];
    int          fifo_wr  = 0;
    int          fifo_rd  = 0;
    int          word_seq = 0;

    assign fifo_empty_i = (fifo_wr == fifo_rd);

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (fifo_re_o && (fifo_wr != fifo_rd)) begin
            fifo_rdata_i <= fifo_mem[fifo_rd[5:0]];
            fifo_rd      <= fifo_rd + 1;
        end
    end

    function automatic logic [63:0] word_val(input int k);
        logic [15:0] k16;
        k16 = 16'(k);
        return {16'hBEEF, k16, 16'h1234 ^ (k16 * 16'd37), ~k16};
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input int n, output int base);
        base = word_seq;
        for (int i = 0; i < n; i++) begin
            fifo_mem[fifo_wr[5:0]] = word_val(word_seq);
            fifo_wr  = fifo_wr + 1;
            word_seq = word_seq + 1;
        end
    endtask

    task automatic push_hdr(input logic [15:0] id);
        exp_q.push_back('{data: {HDR_TAG, 32'h0, id}, sof: 1'b1, eof: 1'b0});
    endtask

    task automatic push_pay(input int k);
        exp_q.push_back('{data: word_val(k), sof: 1'b0, eof: 1'b0});
    endtask

    task automatic push_trl(input logic [31:0] cnt);
        exp_q.push_back('{data: {TRL_TAG, 16'h0, cnt}, sof: 1'b0, eof: 1'b1});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (busy_o && (i < budget)) begin
            tick();
            i++;
        end
        check(name, 64'(busy_o), 64'd0);
    endtask

    task automatic pulse_gate();
        data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
    endtask

    // Monitor: compares each transfer against the scoreboard head.
    logic        stall_q = 1'b0;
    logic [63:0] stall_data;
    logic [1:0]  stall_flags;
    logic        first_pay_seen = 1'b0;
    longint      first_pay_cyc  = 0;
    longint      last_pay_cyc   = 0;

    always @(negedge clk_i) begin
        if (reset_i) begin
            stall_q = 1'b0;
        end else begin
            if (fifo_re_o) begin
                check("read_when_empty", 64'(fifo_empty_i), 64'd0);
            end
            if (stall_q) begin
                check("stall_valid", 64'(out_valid_o), 64'd1);
                check("stall_data", out_data_o, stall_data);
                check("stall_flags", 64'({out_sof_o, out_eof_o}), 64'(stall_flags));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data_o, e.data);
                    check("out_sof", 64'(out_sof_o), 64'(e.sof));
                    check("out_eof", 64'(out_eof_o), 64'(e.eof));
                    if (!e.sof && !e.eof) begin
                        if (!first_pay_seen) begin
                            first_pay_cyc = cyc;
                        end
                        first_pay_seen = 1'b1;
                        last_pay_cyc   = cyc;
                    end
                end
            end
            stall_q     = out_valid_o && !out_ready_i;
            stall_data  = out_data_o;
            stall_flags = {out_sof_o, out_eof_o};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int base_b;

        reset_i      = 1'b1;
        data_valid_i = 1'b0;
        out_ready_i  = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_re", 64'(fifo_re_o), 64'd0);
        check("rst_flags", 64'({out_sof_o, out_eof_o}), 64'd0);
        reset_i     = 1'b0;
        out_ready_i = 1'b1;
        tick();
        check("idle_busy", 64'(busy_o), 64'd0);

        // One-cycle gate pulse, FIFO empty: header then trailer count 0, twice.
        push_hdr(16'd0);
        push_trl(32'd0);
        pulse_gate();
        wait_idle("pulse0_idle", 20);
        push_hdr(16'd1);
        push_trl(32'd0);
        pulse_gate();
        wait_idle("pulse1_idle", 20);

        // 8 words, ready high, gate high 20 cycles: back-to-back payload.
        preload(8, base);
        push_hdr(16'd2);
        for (int i = 0; i < 8; i++) push_pay(base + i);
        push_trl(32'd8);
        first_pay_seen = 1'b0;
        data_valid_i   = 1'b1;
        repeat (20) tick();
        data_valid_i = 1'b0;
        wait_idle("burst8_idle", 30);
        check("burst8_span", 64'(last_pay_cyc - first_pay_cyc), 64'd7);

        // 8 words with ready toggling every cycle.
        preload(8, base);
        push_hdr(16'd3);
        for (int i = 0; i < 8; i++) push_pay(base + i);
        push_trl(32'd8);
        data_valid_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            out_ready_i = ~out_ready_i;
            tick();
        end
        data_valid_i = 1'b0;
        for (int i = 0; (i < 40) && busy_o; i++) begin
            out_ready_i = ~out_ready_i;
            tick();
        end
        check("toggle_idle", 64'(busy_o), 64'd0);
        check("toggle_fifo_left", 64'(fifo_wr - fifo_rd), 64'd0);
        out_ready_i = 1'b1;
        tick();

        // Gate falls with one word in flight behind a stalled buffer:
        // exactly 3 payload words, no reads after the gate drops.
        preload(4, base);
        push_hdr(16'd4);
        for (int i = 0; i < 3; i++) push_pay(base + i);
        push_trl(32'd3);
        data_valid_i = 1'b1;
        tick();                 // HEADER
        tick();                 // header transferred, STREAM
        out_ready_i = 1'b0;
        repeat (3) tick();      // buffer fills to 2
        out_ready_i = 1'b1;
        tick();                 // one pop, one more read in flight
        data_valid_i = 1'b0;
        wait_idle("fall_idle", 20);
        check("fall_fifo_left", 64'(fifo_wr - fifo_rd), 64'd1);

        // Reset mid-STREAM with the buffer full, gate held high through it.
        preload(1, base_b);
        push_hdr(16'd5);
        data_valid_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        repeat (3) tick();
        check("pre_rst_sb", 64'(exp_q.size()), 64'd0);
        check("pre_rst_valid", 64'(out_valid_o), 64'd1);
        check("pre_rst_head", out_data_o, word_val(base + 3));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("mid_rst_re", 64'(fifo_re_o), 64'd0);
        check("mid_rst_valid", 64'(out_valid_o), 64'd0);
        check("mid_rst_flags", 64'({out_sof_o, out_eof_o}), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        push_hdr(16'd0);
        push_trl(32'd0);
        out_ready_i = 1'b1;
        tick();                 // gate high at release counts as a rising edge
        data_valid_i = 1'b0;
        wait_idle("post_rst_idle", 20);

        // burst_id wrap FFFF -> 0000.
        force dut.r_burst_id = 16'hFFFF;
        tick();
        release dut.r_burst_id;
        push_hdr(16'hFFFF);
        push_trl(32'd0);
        pulse_gate();
        wait_idle("wrap0_idle", 20);
        push_hdr(16'h0000);
        push_trl(32'd0);
        pulse_gate();
        wait_idle("wrap1_idle", 20);

        repeat (2) tick();
        check("sb_empty_end", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
